// File: rtl/mem_fetch_unit.sv
// ---------------------------------------------------------------------------
// mem_fetch_unit
//  Sequential byte-fetch stage sitting in front of a small synchronous-read
//  memory. Reads are issued one per cycle from an incrementing fetch address.
//  Each returned byte is tagged with its address and buffered in a prefetch
//  FIFO. The FIFO feeds the decode stage over a valid/ready handshake.
//
//  Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse, begin fetching (honoured only when idle)
//   stop            pulse, stop issuing, let in-flight reads land, go idle
//   load_en         redirect: flush buffer and pipeline, fetch_addr<=load_addr
//   load_addr       redirect target address
//   out_data        FIFO head byte (holds its last value while empty)
//   out_addr        memory address that out_data was read from
//   out_valid       FIFO non-empty
//   out_ready       consumer takes the head on out_valid && out_ready
//   mem_addr        registered memory address
//   mem_rd          registered memory read strobe
//   mem_wr, mem_din tied off; this unit never writes
//   mem_dout        memory read data, valid the cycle after mem_rd
//   busy            fetch FSM is not idle
//   stall_cnt       (FETCH_PERF_EN only) saturating count of RUN cycles in
//                   which issue was blocked because the buffer was fully
//                   reserved
//
//  Optional feature macro: FETCH_PERF_EN
// ---------------------------------------------------------------------------
module mem_fetch_unit #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
`ifdef FETCH_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rd_q;        // read issued last edge (same flop as mem_rd)
  logic              ret_q;       // mem_dout carries a returned byte this cycle
  logic [ADDR_W-1:0] addr_q;      // address belonging to the byte on mem_dout
  logic [CNT_W-1:0]  count;       // bytes held in the FIFO
  logic [CNT_W-1:0]  reserved;    // FIFO count + reads still in flight
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];

  logic              push, pop, issue, head_upd;
  logic [CNT_W-1:0]  cnt_after_pop;
  logic [PTR_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data_nxt;
  logic [ADDR_W-1:0] head_addr_nxt;

  assign rd_q      = mem_rd;
  assign mem_wr    = 1'b0;
  assign mem_din   = '0;
  assign busy      = (state != S_IDLE);
  assign out_valid = (count != '0);

  // A redirect voids both the returning byte and any pop in the same cycle.
  assign push = ret_q && !load_en;
  assign pop  = out_valid && out_ready && !load_en;

  // Next-state. A redirect overrides the normal transitions: only an
  // uninterrupted RUN (no stop) stays in RUN, everything else lands in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (stop)  state_nxt = S_DRAIN;
      S_DRAIN: if (!rd_q && !ret_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (load_en)
      state_nxt = (state == S_RUN && !stop) ? S_RUN : S_IDLE;
  end

  // Issue on the same edge that enters RUN so the first read goes out right
  // after start is sampled. The reservation count guarantees every in-flight
  // byte already owns a FIFO slot, so a return never needs back-pressure.
  assign issue = !load_en && (state_nxt == S_RUN) && (reserved < DEPTH_C);

  // out_data/out_addr are registered copies of the FIFO head so they keep the
  // last delivered value while the FIFO is empty. Work out what the head will
  // be after this edge's pop/push.
  always_comb begin
    cnt_after_pop = count - CNT_W'(pop);
    head_idx      = rd_ptr + PTR_W'(pop);
    head_data_nxt = fifo_data[head_idx];
    head_addr_nxt = fifo_addr[head_idx];
    head_upd      = 1'b0;
    if (cnt_after_pop == '0) begin
      // Nothing left behind the popped entry: the incoming byte becomes head.
      head_data_nxt = mem_dout;
      head_addr_nxt = addr_q;
      head_upd      = push;
    end else begin
      head_upd      = pop;
    end
  end

  // Control and pointer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_addr <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      ret_q      <= 1'b0;
      addr_q     <= '0;
      count      <= '0;
      reserved   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_data   <= '0;
      out_addr   <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= mem_addr;
      if (load_en) begin
        // Flush: the read the memory sampled this edge returns into the void
        // because ret_q is cleared alongside it.
        fetch_addr <= load_addr;
        mem_rd     <= 1'b0;
        ret_q      <= 1'b0;
        count      <= '0;
        reserved   <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        ret_q    <= rd_q;
        mem_rd   <= issue;
        if (issue) begin
          mem_addr   <= fetch_addr;
          fetch_addr <= fetch_addr + ADDR_W'(1);
        end
        reserved <= reserved + CNT_W'(issue) - CNT_W'(pop);
        count    <= count + CNT_W'(push) - CNT_W'(pop);
        wr_ptr   <= wr_ptr + PTR_W'(push);
        rd_ptr   <= rd_ptr + PTR_W'(pop);
        if (head_upd) begin
          out_data <= head_data_nxt;
          out_addr <= head_addr_nxt;
        end
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_dout;
      fifo_addr[wr_ptr] <= addr_q;
    end
  end

`ifdef FETCH_PERF_EN
  // Cycles in RUN where issue was blocked by a fully reserved buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == S_RUN && reserved == DEPTH_C && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_fetch_unit.sv
module tb_mem_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, load_en, out_ready;
  logic [5:0] load_addr;
  logic [7:0] out_data;
  logic [5:0] out_addr;
  logic       out_valid;
  logic [5:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_fetch_unit #(.ADDR_W(6), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load_en(load_en),
    .load_addr(load_addr), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  // Memory model: memory[i] = 8'h40 + i, one-cycle registered read.
  always @(posedge clk) if (mem_rd) mem_dout <= 8'h40 + {2'b00, mem_addr};

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_val(input logic [5:0] a);
    mem_val = 8'h40 + {2'b00, a};
  endfunction

  // Wait (bounded) for a valid head with out_ready held high, check it, let it pop.
  task automatic expect_pop(input logic [5:0] a, input string nm);
    for (int k = 0; k < 20 && !out_valid; k++) step();
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_addr"}, out_addr, a);
      chk({nm, "_data"}, out_data, mem_val(a));
    end
    step();
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 20 && busy; k++) step();
    chk(nm, busy, 0);
  endtask

  typedef struct {
    logic       start, stop, rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [5:0] exp_addr;
    logic       exp_rd;
    logic [5:0] exp_maddr;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [5:0] exp_addr, la;
    int outst, npops, nrd;
    logic pop_now, ld;

    // start, stop, rdy | valid data addr | rd maddr | busy
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 6'd0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 6'd1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 6'd0, 1'b1, 6'd2, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 6'd1, 1'b1, 6'd3, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 6'd2, 1'b1, 6'd4, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 6'd3, 1'b1, 6'd5, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 6'd4, 1'b0, 6'd5, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h45, 6'd5, 1'b0, 6'd5, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h45, 6'd5, 1'b0, 6'd5, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h45, 6'd5, 1'b0, 6'd5, 1'b0};

    start = 0; stop = 0; load_en = 0; load_addr = '0; out_ready = 0;
    rst = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_oaddr", out_addr, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_din", mem_din, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Table: start, steady stream, stop and drain
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; out_ready = tbl[i].rdy;
      step();
      start = 0; stop = 0;
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_oaddr", i), out_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_rd", i), mem_rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].exp_maddr);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // Wrap: redirect to 62 while idle, then start
    load_en = 1; load_addr = 6'd62; step(); load_en = 0;
    chk("wrap_idle", busy, 0);
    out_ready = 1; start = 1; step(); start = 0;
    expect_pop(6'd62, "wrap0");
    expect_pop(6'd63, "wrap1");
    expect_pop(6'd0, "wrap2");
    expect_pop(6'd1, "wrap3");
    stop = 1; step(); stop = 0;
    wait_idle("wrap_idle_end");

    // Full buffer with consumer stalled
    load_en = 1; load_addr = 6'd0; step(); load_en = 0;
    out_ready = 0; start = 1; step(); start = 0;
    nrd = int'(mem_rd);
    for (int k = 0; k < 9; k++) begin step(); nrd += int'(mem_rd); end
    chk("full_reads", nrd, 4);
    chk("full_rd_low", mem_rd, 0);
    chk("full_valid", out_valid, 1);
    chk("full_data", out_data, 8'h40);
    out_ready = 1;
    for (int a = 0; a < 10; a++) expect_pop(6'(a), $sformatf("full_pop%0d", a));

    // Redirect mid-stream: stale bytes must not appear
    stop = 1; step(); stop = 0;
    wait_idle("redir_idle");
    load_en = 1; load_addr = 6'd0; step(); load_en = 0;
    out_ready = 0; start = 1; step(); start = 0;
    repeat (6) step();
    out_ready = 1; step(); step();
    chk("redir_head", out_data, 8'h42);
    load_en = 1; load_addr = 6'd20; step(); load_en = 0;
    chk("redir_flush", out_valid, 0);
    chk("redir_busy", busy, 1);
    for (int a = 20; a < 24; a++) expect_pop(6'(a), $sformatf("redir_pop%0d", a));

    // Stop with two reads in flight
    stop = 1; step(); stop = 0;
    chk("stop_rd0", mem_rd, 0);
    chk("stop_busy0", busy, 1);
    step();
    chk("stop_rd1", mem_rd, 0);
    chk("stop_busy1", busy, 1);
    step();
    chk("stop_busy2", busy, 0);

    // Asynchronous reset between edges
    load_en = 1; load_addr = 6'd0; step(); load_en = 0;
    start = 1; step(); start = 0;
    repeat (4) step();
    chk("arst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", mem_rd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wr", mem_wr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("arst_post_valid", out_valid, 0);

    // Randomized run against a stream scoreboard: delivered bytes must be the
    // contiguous address sequence from the last redirect (or 0 after reset),
    // and reads in flight + buffered bytes never exceed the buffer depth.
    exp_addr = 6'd0; outst = 0; npops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((cyc / 100) % 3 == 0) out_ready = ($urandom_range(0, 9) == 0);
      else                      out_ready = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      ld      = ($urandom_range(0, 49) == 0);
      la      = 6'($urandom_range(0, 63));
      load_en = ld; load_addr = la;
      pop_now = out_valid && out_ready && !ld;
      if (pop_now) begin
        chk("rnd_addr", out_addr, exp_addr);
        chk("rnd_data", out_data, mem_val(exp_addr));
        exp_addr = exp_addr + 6'd1;
        npops++;
      end
      step();
      if (ld) begin
        exp_addr = la;
        outst = 0;
      end else begin
        outst = outst + int'(mem_rd) - int'(pop_now);
      end
      if (outst > 4 || outst < 0) chk("rnd_reserved", outst, 4);
      if (mem_wr) chk("rnd_wr", mem_wr, 0);
    end
    start = 0; stop = 0; load_en = 0;
    chk("rnd_progress", npops > 300, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
